// File: rtl/pla_vector_sweeper_if.sv
// Handshake and capture bundle between the PLA sweeper and its controller.
interface pla_vector_sweeper_if #(
    parameter int N_IN = 7
) ();
    logic                   start;
    logic                   abort;
    logic [N_IN-1:0]        x_out;
    logic                   y_in;
    logic                   busy;
    logic                   done;
    logic                   result_valid;
    logic [(1<<N_IN)-1:0]   truth_table;
    logic [N_IN:0]          onset_count;

    modport slave (
        input  start, abort, y_in,
        output x_out, busy, done, result_valid, truth_table, onset_count
    );

    modport master (
        output start, abort, y_in,
        input  x_out, busy, done, result_valid, truth_table, onset_count
    );
endinterface

// File: rtl/pla_vector_sweeper.sv
// Exhaustive input sweep of a PLA-derived function with truth-table capture.
//
// state    | meaning
// ---------+-------------------------------------------------------
// S_IDLE   | waiting for start; previous results held
// S_SETTLE | x_out driven, down-counting settle cycles
// S_SAMPLE | capture y_in for the current vector, advance
// S_DONE   | one-cycle done pulse, results valid
module pla_vector_sweeper #(
    parameter int N_IN          = 7,
    parameter int SETTLE_CYCLES = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    pla_vector_sweeper_if.slave  sw
);
    localparam int NV = 1 << N_IN;
    localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES + 1) : 1;
    localparam logic [CW-1:0]   SETTLE_LD = CW'(SETTLE_CYCLES);
    localparam logic [N_IN-1:0] IDX_LAST  = '1;

    typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_SAMPLE, S_DONE} state_t;

    // With no settle time every vector is a single SAMPLE cycle.
    localparam state_t VEC_ENTRY = (SETTLE_CYCLES == 0) ? S_SAMPLE : S_SETTLE;

    state_t          state, state_nxt;
    logic [N_IN-1:0] idx;
    logic [CW-1:0]   settle_cnt;
    logic [NV-1:0]   truth_table;
    logic [N_IN:0]   onset_count;
    logic            result_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (sw.start) state_nxt = VEC_ENTRY;
            end
            S_SETTLE: begin
                if (sw.abort)                   state_nxt = S_IDLE;
                else if (settle_cnt <= CW'(1))  state_nxt = S_SAMPLE;
            end
            S_SAMPLE: begin
                if (sw.abort)              state_nxt = S_IDLE;
                else if (idx == IDX_LAST)  state_nxt = S_DONE;
                else                       state_nxt = VEC_ENTRY;
            end
            S_DONE: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Terminal compare comes before the increment, so idx never wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx          <= '0;
            settle_cnt   <= '0;
            truth_table  <= '0;
            onset_count  <= '0;
            result_valid <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (sw.start) begin
                        idx          <= '0;
                        truth_table  <= '0;
                        onset_count  <= '0;
                        result_valid <= 1'b0;
                        settle_cnt   <= SETTLE_LD;
                    end
                end
                S_SETTLE: begin
                    if (sw.abort) idx <= '0;
                    else          settle_cnt <= settle_cnt - CW'(1);
                end
                S_SAMPLE: begin
                    if (sw.abort) begin
                        idx <= '0;
                    end else begin
                        truth_table[idx] <= sw.y_in;
                        onset_count      <= onset_count + {{N_IN{1'b0}}, sw.y_in};
                        if (idx == IDX_LAST) begin
                            result_valid <= 1'b1;
                        end else begin
                            idx        <= idx + N_IN'(1);
                            settle_cnt <= SETTLE_LD;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign sw.x_out        = idx;
    assign sw.busy         = (state == S_SETTLE) || (state == S_SAMPLE);
    assign sw.done         = (state == S_DONE);
    assign sw.result_valid = result_valid;
    assign sw.truth_table  = truth_table;
    assign sw.onset_count  = onset_count;
endmodule

// File: tb/tb_pla_vector_sweeper.sv
// Directed bench for pla_vector_sweeper: sweep table plus abort/reset/restart sequences.
module tb_pla_vector_sweeper;
    localparam int N = 7;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic sel = 1'b0;
    logic start_r = 1'b0;
    logic abort_r = 1'b0;
    int   ymode = 0;

    int nvec = 0;
    int nmis = 0;

    pla_vector_sweeper_if #(.N_IN(N)) if0 ();
    pla_vector_sweeper_if #(.N_IN(N)) if2 ();

    function automatic logic golden(input logic [6:0] x);
        return (x[0] & x[1] & ~x[2]) | ((x[3] ^ x[4]) & x[5]) | (x[6] & ~x[0] & x[2]);
    endfunction

    function automatic logic yfunc(input int m, input logic [6:0] x);
        case (m)
            0:       return 1'b1;
            1:       return 1'b0;
            2:       return golden(x);
            default: return x[0];
        endcase
    endfunction

    assign if0.start = start_r & ~sel;
    assign if2.start = start_r & sel;
    assign if0.abort = abort_r & ~sel;
    assign if2.abort = abort_r & sel;
    assign if0.y_in  = yfunc(ymode, if0.x_out);
    assign if2.y_in  = yfunc(ymode, if2.x_out);

    pla_vector_sweeper #(.N_IN(N), .SETTLE_CYCLES(0)) dut0 (.clk(clk), .rst_n(rst_n), .sw(if0));
    pla_vector_sweeper #(.N_IN(N), .SETTLE_CYCLES(2)) dut2 (.clk(clk), .rst_n(rst_n), .sw(if2));

    logic           s_busy, s_done, s_rv;
    logic [N-1:0]   s_x;
    logic [127:0]   s_tt;
    logic [N:0]     s_on;
    assign s_busy = sel ? if2.busy         : if0.busy;
    assign s_done = sel ? if2.done         : if0.done;
    assign s_rv   = sel ? if2.result_valid : if0.result_valid;
    assign s_x    = sel ? if2.x_out        : if0.x_out;
    assign s_tt   = sel ? if2.truth_table  : if0.truth_table;
    assign s_on   = sel ? if2.onset_count  : if0.onset_count;

    typedef struct {
        logic         sel;
        int           ymode;
        int           exp_done;
        logic [127:0] exp_tt;
        int           exp_onset;
        int           exp_hold;
    } vec_t;

    vec_t vt[5];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Cycle 1 is the cycle right after the edge that samples start.
    task automatic run_sweep(input bit restart_at10, input bit abort_in_done,
                             output int done_cyc, output int ndone,
                             output int hold1, output int hold_last);
        int cyc;
        start_r = 1'b1;
        tick();
        start_r = 1'b0;
        cyc = 1; done_cyc = -1; ndone = 0; hold1 = 0; hold_last = 0;
        while (cyc <= 600) begin
            if (s_busy && s_x == 7'd1)   hold1++;
            if (s_busy && s_x == 7'd127) hold_last++;
            start_r = restart_at10 && s_busy && (s_x == 7'd10);
            if (s_done) begin
                ndone++;
                if (done_cyc < 0) done_cyc = cyc;
                abort_r = abort_in_done;
            end else begin
                abort_r = 1'b0;
            end
            if (done_cyc >= 0 && cyc >= done_cyc + 3) break;
            tick();
            cyc++;
        end
        start_r = 1'b0;
        abort_r = 1'b0;
    endtask

    initial begin
        logic [127:0] gold_tt;
        logic [127:0] alt_tt;
        logic [127:0] ones_tt;
        int gold_cnt;
        int dc, nd, h1, hl, cnt;

        gold_tt = '0;
        gold_cnt = 0;
        for (int k = 0; k < 128; k++) begin
            gold_tt[k] = golden(7'(k));
            if (gold_tt[k]) gold_cnt++;
        end
        alt_tt  = {64{2'b10}};
        ones_tt = {128{1'b1}};

        vt[0] = '{sel: 1'b0, ymode: 0, exp_done: 129, exp_tt: ones_tt,  exp_onset: 128,      exp_hold: 1};
        vt[1] = '{sel: 1'b0, ymode: 1, exp_done: 129, exp_tt: '0,       exp_onset: 0,        exp_hold: 1};
        vt[2] = '{sel: 1'b0, ymode: 2, exp_done: 129, exp_tt: gold_tt,  exp_onset: gold_cnt, exp_hold: 1};
        vt[3] = '{sel: 1'b1, ymode: 3, exp_done: 385, exp_tt: alt_tt,   exp_onset: 64,       exp_hold: 3};
        vt[4] = '{sel: 1'b1, ymode: 2, exp_done: 385, exp_tt: gold_tt,  exp_onset: gold_cnt, exp_hold: 3};

        #12;
        chk("reset_busy0", 128'(if0.busy), 128'(0));
        chk("reset_x0", 128'(if0.x_out), 128'(0));
        chk("reset_rv2", 128'(if2.result_valid), 128'(0));
        chk("reset_tt2", if2.truth_table, 128'(0));
        #1 rst_n = 1'b1;
        tick();

        for (int i = 0; i < 5; i++) begin
            sel   = vt[i].sel;
            ymode = vt[i].ymode;
            tick();
            run_sweep(1'b0, 1'b0, dc, nd, h1, hl);
            chk($sformatf("v%0d_done_cycle", i), 128'(dc), 128'(vt[i].exp_done));
            chk($sformatf("v%0d_done_pulses", i), 128'(nd), 128'(1));
            chk($sformatf("v%0d_truth_table", i), s_tt, vt[i].exp_tt);
            chk($sformatf("v%0d_onset", i), 128'(s_on), 128'(vt[i].exp_onset));
            chk($sformatf("v%0d_valid", i), 128'(s_rv), 128'(1));
            chk($sformatf("v%0d_busy_after", i), 128'(s_busy), 128'(0));
            chk($sformatf("v%0d_x_last", i), 128'(s_x), 128'(127));
            chk($sformatf("v%0d_hold_first", i), 128'(h1), 128'(vt[i].exp_hold));
            chk($sformatf("v%0d_hold_last", i), 128'(hl), 128'(vt[i].exp_hold));
        end

        // Abort while x_out == 50 on the zero-settle instance.
        sel = 1'b0; ymode = 0;
        tick();
        start_r = 1'b1;
        tick();
        start_r = 1'b0;
        cnt = 0;
        while (s_x != 7'd50 && cnt < 200) begin
            tick();
            cnt++;
        end
        chk("abort_reached_50", 128'(s_x), 128'(50));
        abort_r = 1'b1;
        tick();
        abort_r = 1'b0;
        chk("abort_busy", 128'(s_busy), 128'(0));
        chk("abort_valid", 128'(s_rv), 128'(0));
        chk("abort_x", 128'(s_x), 128'(0));
        nd = 0;
        for (int c = 0; c < 200; c++) begin
            if (s_done) nd++;
            tick();
        end
        chk("abort_no_done", 128'(nd), 128'(0));

        // start and abort together in IDLE: start wins.
        start_r = 1'b1; abort_r = 1'b1;
        tick();
        start_r = 1'b0; abort_r = 1'b0;
        chk("start_beats_abort", 128'(s_busy), 128'(1));
        abort_r = 1'b1;
        tick();
        abort_r = 1'b0;
        chk("second_abort_idle", 128'(s_busy), 128'(0));

        // Restart pulse mid-sweep is ignored; abort during DONE is ignored.
        ymode = 2;
        tick();
        run_sweep(1'b1, 1'b1, dc, nd, h1, hl);
        chk("restart_done_cycle", 128'(dc), 128'(129));
        chk("restart_done_pulses", 128'(nd), 128'(1));
        chk("restart_truth_table", s_tt, gold_tt);
        chk("restart_onset", 128'(s_on), 128'(gold_cnt));
        chk("abort_in_done_valid", 128'(s_rv), 128'(1));

        // Asynchronous reset in the middle of SETTLE.
        sel = 1'b1; ymode = 0;
        tick();
        start_r = 1'b1;
        tick();
        start_r = 1'b0;
        tick();
        chk("pre_reset_busy", 128'(s_busy), 128'(1));
        rst_n = 1'b0;
        #1;
        chk("async_busy", 128'(s_busy), 128'(0));
        chk("async_x", 128'(s_x), 128'(0));
        chk("async_done", 128'(s_done), 128'(0));
        chk("async_valid", 128'(s_rv), 128'(0));
        chk("async_tt0", if0.truth_table, 128'(0));
        chk("async_onset0", 128'(if0.onset_count), 128'(0));
        #1 rst_n = 1'b1;
        nd = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (s_done || s_busy) nd++;
        end
        chk("post_reset_idle", 128'(nd), 128'(0));

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule
